// File: rtl/ld571_to_affine.sv
// ld571_to_affine: Lopez-Dahab (X,Y,Z) -> affine (X/Z, Y/Z^2) over GF(2^571), Itoh-Tsujii inversion.
// Define ON_CURVE_CHECK_EN to add the on_curve output and the curve-equation check.
module squerer_571 (
    input  logic [570:0] a,
    output logic [570:0] y
);
    logic [1140:0] s;
    always_comb begin
        s = '0;
        for (int i = 0; i < 571; i++) s[2*i] = a[i];
        // fold x^571 = x^10 + x^5 + x^2 + 1 from the top down
        for (int i = 1140; i >= 571; i--)
            if (s[i]) s[i-571 +: 11] = s[i-571 +: 11] ^ 11'b10000100101;
        y = s[570:0];
    end
endmodule

module gf2m_mult571 (
    input  logic [570:0] a,
    input  logic [570:0] b,
    output logic [570:0] p
);
    logic [570:0] r;
    always_comb begin
        r = '0;
        for (int i = 570; i >= 0; i--) begin
            r = {r[569:0], 1'b0} ^ (r[570] ? 571'h425 : 571'h0);
            if (b[i]) r = r ^ a;
        end
        p = r;
    end
endmodule

module ld571_to_affine #(
    parameter int M = 571,
    parameter int MULT_WAIT = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [M-1:0] X,
    input  logic [M-1:0] Y,
    input  logic [M-1:0] Z,
    output logic [M-1:0] x_aff,
    output logic [M-1:0] y_aff,
    output logic         inf,
    output logic         busy,
    output logic         done
`ifdef ON_CURVE_CHECK_EN
    , output logic       on_curve
`endif
);
    localparam logic [15:0] E = 16'd570;
`ifdef ON_CURVE_CHECK_EN
    localparam logic [575:0] BW = 576'h02F40E7E2221F295DE297117B7F3D62F5C6A97FFCB8CEFF1CD6BA8CE4A9A18AD84FFABBD8EFA59332BE7AD6756A66E294AFD185A78FF12AA520E4DE739BACA0C7FFEFF7F2955727A;
    logic chk;
`endif
    typedef enum logic [3:0] {IDLE, INIT, ISQ, IMUL, ZSQ, XMUL, Z2SQ, YMUL,
                              CX2, CY2, CXY, CX3, CCMP, FIN, DONE} state_t;
    state_t state, nxt;
    logic [M-1:0] xr, yr, zr, acc, t, ma, mb, opa, opb, sq_in, sq_out, prod;
    logic [9:0] k, kn, sq_cnt;
    logic [3:0] bidx;
    logic [1:0] mult_cnt;
    logic phase, in_mul, mul_last, add_next;

    squerer_571  u_sqr (.a(sq_in), .y(sq_out));
    gf2m_mult571 u_mul (.a(ma), .b(mb), .p(prod));

    // phase=1 while doing the extra "*Z" step of a set exponent bit
    assign in_mul   = state inside {IMUL, XMUL, YMUL, CXY, CX3};
    assign mul_last = mult_cnt == 2'(MULT_WAIT);
    assign add_next = !phase && E[bidx];
    assign kn       = phase ? k + 10'd1 : {k[8:0], 1'b0};

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else     state <= nxt;

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (start) nxt = INIT;
            INIT:    nxt = ISQ;
            ISQ:     if (sq_cnt == 10'd1) nxt = IMUL;
            IMUL:    if (mul_last) nxt = (add_next || bidx != 4'd0) ? ISQ : ZSQ;
            ZSQ:     nxt = XMUL;
            XMUL:    if (mul_last) nxt = Z2SQ;
            Z2SQ:    nxt = YMUL;
`ifdef ON_CURVE_CHECK_EN
            YMUL:    if (mul_last) nxt = CX2;
            CX2:     nxt = CY2;
            CY2:     nxt = CXY;
            CXY:     if (mul_last) nxt = CX3;
            CX3:     if (mul_last) nxt = CCMP;
            CCMP:    nxt = FIN;
`else
            YMUL:    if (mul_last) nxt = FIN;
`endif
            FIN:     nxt = DONE;
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = state != IDLE;
        done = state == DONE;
    end

    always_comb begin
        opa   = acc;
        opb   = phase ? zr : t;
        sq_in = acc;
        case (state)
            XMUL:    begin opa = xr; opb = acc; end
            YMUL:    begin opa = yr; opb = acc; end
            CXY:     begin opa = xr; opb = yr; end
            CX3:     begin opa = t;  opb = xr; end
            CX2:     sq_in = xr;
            CY2:     sq_in = yr;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) mult_cnt <= '0;
        else     mult_cnt <= (in_mul && !mul_last) ? mult_cnt + 2'd1 : 2'd0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            {xr, yr, zr, acc, t, ma, mb, x_aff, y_aff} <= '0;
            {k, sq_cnt, bidx, phase, inf} <= '0;
`ifdef ON_CURVE_CHECK_EN
            {chk, on_curve} <= '0;
`endif
        end else begin
            if (in_mul && mult_cnt == 2'd0) begin
                ma <= opa;
                mb <= opb;
            end
            case (state)
                IDLE: if (start) begin
                    xr  <= X;
                    yr  <= Y;
                    zr  <= Z;
                    inf <= Z == '0;
                end
                INIT: begin
                    acc    <= zr;
                    t      <= zr;
                    k      <= 10'd1;
                    sq_cnt <= 10'd1;
                    bidx   <= 4'd8;
                    phase  <= 1'b0;
                end
                ISQ: begin
                    acc    <= sq_out;
                    sq_cnt <= sq_cnt - 10'd1;
                end
                // t keeps beta_k as the multiplicand for the next doubling
                IMUL: if (mul_last) begin
                    acc    <= prod;
                    t      <= prod;
                    phase  <= add_next;
                    k      <= kn;
                    sq_cnt <= add_next ? 10'd1 : kn;
                    if (!add_next) bidx <= bidx - 4'd1;
                end
                ZSQ, Z2SQ: acc <= sq_out;
                XMUL: if (mul_last) xr <= prod;
                YMUL: if (mul_last) yr <= prod;
`ifdef ON_CURVE_CHECK_EN
                CX2:  t   <= sq_out;
                CY2:  acc <= sq_out;
                CXY:  if (mul_last) acc <= acc ^ prod;
                CX3:  if (mul_last) zr <= prod;
                CCMP: chk <= acc == (zr ^ t ^ BW[M-1:0]);
`endif
                FIN: begin
                    x_aff <= xr;
                    y_aff <= yr;
`ifdef ON_CURVE_CHECK_EN
                    on_curve <= inf | chk;
`endif
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ld571_to_affine.sv
// tb_ld571_to_affine: directed checks of the LD->affine converter: latency, results, infinity, start hold, reset abort.
module tb_ld571_to_affine;
`ifdef ON_CURVE_CHECK_EN
    localparam int LAT = 644;
    logic on_curve;
`else
    localparam int LAT = 633;
`endif
    logic clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [570:0] X = '0, Y = '0, Z = '0, x_aff, y_aff;
    logic inf, busy, done, busy1, done_after, busy_after;
    logic [570:0] rx, ry, rz;
    int n_vec = 0, n_err = 0, lat;

    always #5 clk = ~clk;

    ld571_to_affine dut (
        .clk(clk), .rst(rst), .start(start), .X(X), .Y(Y), .Z(Z),
        .x_aff(x_aff), .y_aff(y_aff), .inf(inf), .busy(busy), .done(done)
`ifdef ON_CURVE_CHECK_EN
        , .on_curve(on_curve)
`endif
    );

    // schoolbook product, then two folds of the high half
    function automatic logic [570:0] gmul(input logic [570:0] a, input logic [570:0] b);
        logic [1140:0] p, h;
        p = '0;
        for (int i = 0; i < 571; i++) if (b[i]) p = p ^ ({570'd0, a} << i);
        for (int r = 0; r < 2; r++) begin
            h = p >> 571;
            p = {570'd0, p[570:0]} ^ h ^ (h << 2) ^ (h << 5) ^ (h << 10);
        end
        return p[570:0];
    endfunction

    function automatic logic [570:0] rnd();
        logic [570:0] r;
        r = '0;
        for (int i = 0; i < 18; i++) r = {r[538:0], 32'($urandom())};
        return r;
    endfunction

    task automatic check(input string tag, input logic [570:0] got, input logic [570:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic run(input logic [570:0] xi, input logic [570:0] yi, input logic [570:0] zi);
        X = xi; Y = yi; Z = zi; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        busy1 = busy;
        lat = 0;
        while (done !== 1'b1 && lat < 2000) begin
            @(posedge clk); #1;
            lat++;
        end
        @(posedge clk); #1;
        done_after = done;
        busy_after = busy;
    endtask

    task automatic check_run(input string tag, input logic [570:0] xe, input logic [570:0] ye, input logic ie);
        check({tag, " latency"}, 571'(lat), 571'(LAT));
        check({tag, " x_aff"}, x_aff, xe);
        check({tag, " y_aff"}, y_aff, ye);
        check({tag, " inf"}, 571'(inf), 571'(ie));
        check({tag, " done width"}, 571'(done_after), 571'd0);
    endtask

    initial begin
        int dones, busy_low, first_done, second_done;
        repeat (3) @(posedge clk);
        #1;
        check("reset x_aff", x_aff, 571'd0);
        check("reset y_aff", y_aff, 571'd0);
        check("reset inf/busy/done", 571'({inf, busy, done}), 571'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        run(571'd5, 571'd7, 571'd1);
        check_run("z=1", 571'd5, 571'd7, 1'b0);
        check("busy after capture", 571'(busy1), 571'd1);
        check("busy after done", 571'(busy_after), 571'd0);

        run(571'd2, 571'd4, 571'd2);
        check_run("z=t", 571'd1, 571'd1, 1'b0);

        run(571'd123, 571'd456, 571'd0);
        check_run("z=0", 571'd0, 571'd0, 1'b1);
`ifdef ON_CURVE_CHECK_EN
        check("z=0 on_curve", 571'(on_curve), 571'd1);
`endif

        for (int v = 0; v < 10; v++) begin
            rx = rnd(); ry = rnd(); rz = rnd();
            if (rz == '0) rz = 571'd1;
            run(gmul(rx, rz), gmul(ry, gmul(rz, rz)), rz);
            check_run("random", rx, ry, 1'b0);
        end

        // start held high with churning inputs: only the captured values matter
        dones = 0; busy_low = 0; first_done = 0; second_done = 0;
        X = 571'd3; Y = 571'd9; Z = 571'd1; start = 1'b1;
        for (int c = 1; c <= 2 * LAT + 40; c++) begin
            @(posedge clk); #1;
            if (c == 700) start = 1'b0;
            if (done) begin
                dones++;
                if (dones == 1) begin
                    first_done = c;
                    check("hold run1 x_aff", x_aff, 571'd3);
                    check("hold run1 y_aff", y_aff, 571'd9);
                    X = 571'd2; Y = 571'd4; Z = 571'd2;
                end else if (dones == 2) begin
                    second_done = c;
                    check("hold run2 x_aff", x_aff, 571'd1);
                    check("hold run2 y_aff", y_aff, 571'd1);
                end
            end else if (dones == 0) begin
                X = rnd(); Y = rnd(); Z = rnd();
            end
            if (!busy && dones < 2) busy_low++;
        end
        check("hold done count", 571'(dones), 571'd2);
        check("hold first done", 571'(first_done), 571'(LAT + 1));
        check("hold second done", 571'(second_done), 571'(2 * LAT + 3));
        check("hold busy gap", 571'(busy_low), 571'd1);

        // reset at cycle 300 of a run aborts it
        X = 571'd5; Y = 571'd7; Z = 571'd1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (299) @(posedge clk);
        #1 rst = 1'b1;
        #2;
        check("abort x_aff", x_aff, 571'd0);
        check("abort y_aff", y_aff, 571'd0);
        check("abort inf/busy/done", 571'({inf, busy, done}), 571'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        dones = 0;
        for (int c = 0; c < 700; c++) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        check("abort no done", 571'(dones), 571'd0);
        run(571'd2, 571'd4, 571'd2);
        check_run("after abort", 571'd1, 571'd1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
